// File: rtl/skinny_prng_pkg.sv
// Shared types, tap constants and the 17-step advance for the Skinny fresh-mask PRNG.
package skinny_prng_pkg;

    localparam int LFSR_W = 64;
    localparam int STEPS_PER_CLK = 17;

    localparam int TAP_0 = 63;
    localparam int TAP_1 = 62;
    localparam int TAP_2 = 60;
    localparam int TAP_3 = 59;

    // An all-zero LFSR would lock up, so a zero seed loads this instead.
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } prng_state_e;

    // x^64+x^63+x^61+x^60+1, Fibonacci form, feedback shifted in at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step17(input logic [LFSR_W-1:0] s_in);
        logic [LFSR_W-1:0] s;
        logic              fb;
        s = s_in;
        for (int i = 0; i < STEPS_PER_CLK; i++) begin
            fb = s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3];
            s  = {s[LFSR_W-2:0], fb};
        end
        return s;
    endfunction

endpackage

// File: rtl/skinny_fresh_lfsr_core.sv
// LFSR state register with seed load (zero-seed substituted) and 17-step advance.
module skinny_fresh_lfsr_core
    import skinny_prng_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // Load wins over advance so a reseed never mixes in an old-state step.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (load_val == '0) ? ZERO_SEED_SUB : load_val;
        end else if (adv) begin
            lfsr_d = lfsr_step17(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/skinny_sbox_fresh_prng.sv
// Fresh-mask source for the HPC2 Skinny S-box: seed handshake, warm-up, stall and reseed request.
module skinny_sbox_fresh_prng
    import skinny_prng_pkg::*;
#(
    parameter int FRESH_WIDTH     = 17,
    parameter int LFSR_WIDTH      = 64,
    parameter int WARMUP_CYCLES   = 8,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LFSR_WIDTH-1:0]  seed,
    input  logic                   seed_valid,
    output logic                   seed_ready,
    input  logic                   en,
    output logic [FRESH_WIDTH-1:0] Fresh,
    output logic                   fresh_valid,
    output logic                   reseed_req
);

    localparam logic [7:0]  WARM_LAST  = 8'(WARMUP_CYCLES - 1);
    localparam logic [15:0] RESEED_LIM = 16'(RESEED_INTERVAL);

    prng_state_e       state_q, state_d;
    logic [7:0]        warm_cnt_q, warm_cnt_d;
    logic [15:0]       run_cnt_q, run_cnt_d;
    logic              reseed_q, reseed_d;
    logic              load, adv, seed_fire;
    logic [LFSR_W-1:0] lfsr_state;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= RESEED_LIM) ? RESEED_LIM : v + 16'd1;
    endfunction

    assign seed_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign fresh_valid = (state_q == ST_RUN);
    assign reseed_req  = reseed_q;
    assign seed_fire   = seed_valid && seed_ready;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        run_cnt_d  = run_cnt_q;
        reseed_d   = reseed_q;
        load       = 1'b0;
        adv        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seed_fire) begin
                    load       = 1'b1;
                    warm_cnt_d = '0;
                    state_d    = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                adv = 1'b1;
                if (warm_cnt_q == WARM_LAST) begin
                    warm_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (seed_fire) begin
                    load       = 1'b1;
                    warm_cnt_d = '0;
                    run_cnt_d  = '0;
                    reseed_d   = 1'b0;
                    state_d    = ST_WARMUP;
                end else if (en) begin
                    adv       = 1'b1;
                    run_cnt_d = sat_inc(run_cnt_q);
                    if (run_cnt_d == RESEED_LIM) begin
                        reseed_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            warm_cnt_q <= '0;
            run_cnt_q  <= '0;
            reseed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            run_cnt_q  <= run_cnt_d;
            reseed_q   <= reseed_d;
        end
    end

    skinny_fresh_lfsr_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (seed),
        .adv      (adv),
        .state    (lfsr_state)
    );

    // Once seeded, the state must never collapse to the lock-up value.
    always_ff @(posedge clk) begin
        if (!rst && state_q != ST_IDLE) begin
            assert (lfsr_state != '0);
        end
    end

    assign Fresh = lfsr_state[FRESH_WIDTH-1:0];

endmodule

// File: tb/tb_skinny_sbox_fresh_prng.sv
// Directed bench: default-parameter instance plus a short warm-up / short interval instance.
module tb_skinny_sbox_fresh_prng;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] seed, seed2;
    logic        seed_valid, seed_valid2;
    logic        en, en2;
    logic        seed_ready, seed_ready2;
    logic [16:0] Fresh, Fresh2;
    logic        fresh_valid, fresh_valid2;
    logic        reseed_req, reseed_req2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_cnt = 0;
    logic [63:0] m, m2;

    skinny_sbox_fresh_prng u_dut (
        .clk         (clk),
        .rst         (rst),
        .seed        (seed),
        .seed_valid  (seed_valid),
        .seed_ready  (seed_ready),
        .en          (en),
        .Fresh       (Fresh),
        .fresh_valid (fresh_valid),
        .reseed_req  (reseed_req)
    );

    skinny_sbox_fresh_prng #(
        .WARMUP_CYCLES   (1),
        .RESEED_INTERVAL (4)
    ) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .seed        (seed2),
        .seed_valid  (seed_valid2),
        .seed_ready  (seed_ready2),
        .en          (en2),
        .Fresh       (Fresh2),
        .fresh_valid (fresh_valid2),
        .reseed_req  (reseed_req2)
    );

    function automatic logic [63:0] tb_step(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        for (int k = 0; k < 17; k++) begin
            r = {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        seed = '0; seed_valid = 1'b0; en = 1'b0;
        seed2 = '0; seed_valid2 = 1'b0; en2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (fresh_valid !== 1'b0 || Fresh !== 17'h0 || seed_ready !== 1'b1 || reseed_req !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: fv=%b fresh=%h rdy=%b rr=%b, required fv=0 fresh=0 rdy=1 rr=0",
                         i, fresh_valid, Fresh, seed_ready, reseed_req);
            end
        end
    endtask

    task automatic test_seed_load();
        seed = 64'h0123_4567_89AB_CDEF;
        seed_valid = 1'b1;
        en = 1'b0;
        @(negedge clk);
        seed_valid = 1'b0;
        m = seed;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (seed_ready !== 1'b0 || fresh_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL warmup_flags cyc %0d: rdy=%b fv=%b, required rdy=0 fv=0", i, seed_ready, fresh_valid);
            end
            @(negedge clk);
        end
        repeat (8) m = tb_step(m);
        n_tests++;
        if (fresh_valid !== 1'b1 || seed_ready !== 1'b1 || Fresh !== m[16:0]) begin
            n_fail++;
            $display("FAIL run_entry: fv=%b rdy=%b fresh=%h, required fv=1 rdy=1 fresh=%h",
                     fresh_valid, seed_ready, Fresh, m[16:0]);
        end
        exp_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            en = ((i % 5) != 3);
            @(negedge clk);
            if (en) begin
                m = tb_step(m);
                exp_cnt++;
            end
            n_tests++;
            if (Fresh !== m[16:0] || fresh_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL run_stream cyc %0d: fresh=%h fv=%b, required fresh=%h fv=1", i, Fresh, fresh_valid, m[16:0]);
            end
        end
    endtask

    task automatic test_stall();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (Fresh !== m[16:0] || fresh_valid !== 1'b1 || u_dut.run_cnt_q !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL stall cyc %0d: fresh=%h fv=%b cnt=%0d, required fresh=%h fv=1 cnt=%0d",
                         i, Fresh, fresh_valid, u_dut.run_cnt_q, m[16:0], exp_cnt);
            end
        end
    endtask

    task automatic test_zero_seed();
        seed2 = '0;
        seed_valid2 = 1'b1;
        en2 = 1'b0;
        @(negedge clk);
        seed_valid2 = 1'b0;
        n_tests++;
        if (u_dut2.u_core.lfsr_q !== 64'h1 || fresh_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_seed_load: lfsr=%h fv=%b, required lfsr=0000000000000001 fv=0",
                     u_dut2.u_core.lfsr_q, fresh_valid2);
        end
        @(negedge clk);
        n_tests++;
        if (u_dut2.u_core.lfsr_q !== 64'h0000_0000_0002_0000 || Fresh2 !== 17'h0 || fresh_valid2 !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_seed_adv: lfsr=%h fresh=%h fv=%b, required lfsr=0000000000020000 fresh=0 fv=1",
                     u_dut2.u_core.lfsr_q, Fresh2, fresh_valid2);
        end
        m2 = 64'h0000_0000_0002_0000;
    endtask

    task automatic test_reseed();
        en2 = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            m2 = tb_step(m2);
            n_tests++;
            if (Fresh2 !== m2[16:0] || reseed_req2 !== (i >= 4)) begin
                n_fail++;
                $display("FAIL reseed_req adv %0d: fresh=%h rr=%b, required fresh=%h rr=%b",
                         i, Fresh2, reseed_req2, m2[16:0], (i >= 4));
            end
        end
        seed2 = 64'hFEDC_BA98_7654_3210;
        seed_valid2 = 1'b1;
        @(negedge clk);
        seed_valid2 = 1'b0;
        m2 = seed2;
        n_tests++;
        if (fresh_valid2 !== 1'b0 || reseed_req2 !== 1'b0 || seed_ready2 !== 1'b0 || u_dut2.u_core.lfsr_q !== m2) begin
            n_fail++;
            $display("FAIL reseed_accept: fv=%b rr=%b rdy=%b lfsr=%h, required fv=0 rr=0 rdy=0 lfsr=%h",
                     fresh_valid2, reseed_req2, seed_ready2, u_dut2.u_core.lfsr_q, m2);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m2 = tb_step(m2);
            n_tests++;
            if (fresh_valid2 !== 1'b1 || reseed_req2 !== 1'b0 || Fresh2 !== m2[16:0]) begin
                n_fail++;
                $display("FAIL reseed_resume cyc %0d: fv=%b rr=%b fresh=%h, required fv=1 rr=0 fresh=%h",
                         i, fresh_valid2, reseed_req2, Fresh2, m2[16:0]);
            end
        end
        en2 = 1'b0;
    endtask

    task automatic test_async_reset();
        seed = 64'hA5A5_5A5A_0F0F_F0F0;
        seed_valid = 1'b1;
        en = 1'b0;
        @(negedge clk);
        seed_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (seed_ready !== 1'b1 || fresh_valid !== 1'b0 || Fresh !== 17'h0 || reseed_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b fv=%b fresh=%h rr=%b, required rdy=1 fv=0 fresh=0 rr=0",
                     seed_ready, fresh_valid, Fresh, reseed_req);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (seed_ready !== 1'b1 || fresh_valid !== 1'b0 || Fresh !== 17'h0) begin
            n_fail++;
            $display("FAIL post_reset_idle: rdy=%b fv=%b fresh=%h, required rdy=1 fv=0 fresh=0",
                     seed_ready, fresh_valid, Fresh);
        end
        seed = 64'h0123_4567_89AB_CDEF;
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        m = seed;
        repeat (8) begin
            m = tb_step(m);
            @(negedge clk);
        end
        n_tests++;
        if (fresh_valid !== 1'b1 || Fresh !== m[16:0]) begin
            n_fail++;
            $display("FAIL post_reset_seed: fv=%b fresh=%h, required fv=1 fresh=%h", fresh_valid, Fresh, m[16:0]);
        end
    endtask

    initial begin
        test_reset();
        test_seed_load();
        test_stall();
        test_zero_seed();
        test_reseed();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/skinny_sbox_fresh_prng.md
# skinny_sbox_fresh_prng

Masked randomness source sitting directly upstream of the first-order HPC2 pipelined Skinny S-box (`Fresh[16:0]` consumer). It keeps a 64-bit Fibonacci LFSR and advances it 17 steps per clock, so the S-box gets 17 new fresh-mask bits every cycle. Seeding uses a valid/ready handshake, with a mandatory warm-up period and a reseed-request counter. A stall input freezes the output in step with the S-box data feed.

## Interface
- `FRESH_WIDTH`, 17: fresh bits per cycle; must equal the S-box `Fresh` width.
- `LFSR_WIDTH`, 64: state width; only 64 is supported.
- `WARMUP_CYCLES`, 8: discarded advances after each seed load; legal range 1..255.
- `RESEED_INTERVAL`, 1024: RUN advances before `reseed_req` asserts; legal range 1..65535.
- `clk`  in  1: single clock for the block.
- `rst`  in  1: asynchronous, active-high reset.
- `seed`  in  64: seed value.
- `seed_valid`  in  1: seed offered.
- `seed_ready`  out  1: seed accepted on `seed_valid && seed_ready` at a rising edge.
- `en`  in  1: advance enable in RUN; low means stall.
- `Fresh`  out  17: fresh randomness to the S-box.
- `fresh_valid`  out  1: `Fresh` is usable.
- `reseed_req`  out  1: sticky; the interval has been exhausted.

## Operation
- Advance function: 17 unrolled steps of `fb = s[63]^s[62]^s[60]^s[59]; s = {s[62:0], fb}`. Polynomial x^64+x^63+x^61+x^60+1.
- `Fresh = lfsr_q[16:0]`, taken directly from the state register. There is no logic between the flop and the port, so the output is glitch-free.
- All-zero seed is replaced by `64'h0000_0000_0000_0001` on load. The state register is never all-zero after a load.
- FSM states:
  - IDLE (unseeded): `seed_ready=1`, `fresh_valid=0`, LFSR holds.
  - WARMUP: `seed_ready=0`, `fresh_valid=0`.
    - LFSR advances every cycle, ignoring `en`.
    - An 8-bit counter counts advances; after `WARMUP_CYCLES` advances, go to RUN.
  - RUN: `seed_ready=1`, `fresh_valid=1`.
    - LFSR advances only when `en=1`; `Fresh` holds when `en=0`.
    - A 16-bit counter counts advances.
- Transitions:
  - IDLE, seed accepted → WARMUP. The load sets `lfsr_q` and clears the warm-up counter.
  - WARMUP, counter reaches `WARMUP_CYCLES-1` on the advancing edge → RUN.
  - RUN, seed accepted → WARMUP (reseed). The load has priority over `en`; no advance happens on that edge.
    - The load clears the RUN counter and `reseed_req`.
- `reseed_req`:
  - Set on the edge where the RUN counter reaches `RESEED_INTERVAL`.
  - Stays high until the next seed load or reset.
  - Generation continues while it is high.
  - The RUN counter saturates and does not wrap.
- `seed_valid` in WARMUP is ignored; the producer holds the seed until ready.

## Timing
- Reset values:
  - State IDLE, `lfsr_q=0`, `Fresh=0`, `fresh_valid=0`, `reseed_req=0`, `seed_ready=1`, both counters 0.
- Seed accepted at edge k:
  - `seed_ready` falls after edge k.
  - WARMUP advances run at edges k+1 .. k+`WARMUP_CYCLES`.
  - `fresh_valid` rises after edge k+`WARMUP_CYCLES`.
- In RUN, each `en=1` edge produces a new `Fresh` visible in the following cycle.
  - The S-box samples `Fresh` combinationally in the same cycle as its data.
  - Stalling `en` together with the S-box data feed keeps masks and shares aligned.
- Reseed in RUN: `fresh_valid` falls after the accepting edge. There is no cycle in which a pre-reseed value is flagged valid.
- Reset asserted mid-operation (any state) clears everything immediately, with no clock needed. After release the block waits in IDLE for a new seed.

## Structure
- Package `skinny_prng_pkg`:
  - FSM state enum (IDLE, WARMUP, RUN).
  - Tap constants 63/62/60/59.
  - Zero-seed substitute constant.
  - Pure function `lfsr_step17(logic [63:0])`.
- One sub-module, `skinny_fresh_lfsr_core`:
  - Holds the state register, load mux, zero-seed substitution and 17-step advance.
  - Inputs: `load`, `load_val`, `adv`.
  - Output: the state.
- The top holds the FSM, both counters and the handshake.

## Test plan
- Reset, then no seed for 20 cycles → `fresh_valid=0`, `Fresh=0`, `seed_ready=1`, `reseed_req=0` throughout.
- Seed `64'h0123_4567_89AB_CDEF` accepted at edge 5 with default parameters:
  - `seed_ready=0` during cycles 6–13.
  - `fresh_valid` rises after edge 13.
  - `Fresh` matches the golden model (8 warm-up advances, then one per `en` edge) for 100 cycles.
- Seed 0 with `WARMUP_CYCLES=1` → the core loads `64'h1`. After one advance, `lfsr_q=64'h0000_0000_0002_0000` and `Fresh=17'h0`; the state is never all-zero.
- In RUN, `en` low for 3 cycles → `Fresh` unchanged; `fresh_valid` stays 1; the RUN counter does not increment.
- With `RESEED_INTERVAL=4`:
  - `reseed_req` rises after the 4th `en` advance and stays high through 10 more advances.
  - A new seed clears it and drops `fresh_valid` for `WARMUP_CYCLES` cycles.
- `rst` pulsed asynchronously mid-WARMUP (between edges) → all outputs at reset values before the next edge. A seed offered after release is accepted normally.
